// File: rtl/lock_watchdog.sv
// lock_watchdog
// Clock-lock supervisor for the startup clock domain. Once RUN has been
// stable for a while it watches the DAQ MMCM, trigger MMCM and QPLL lock
// indicators. It debounces lock drops and counts the ones that last long
// enough. A loss that persists raises a RESTART_REQ pulse, which the reset
// manager turns into SYS_RST.
//
// Ports
//   STUP_CLK        startup clock; every flop uses its rising edge
//   SYS_RST         asynchronous active-high reset
//   RUN             async, system-running indication
//   DAQ_MMCM_LOCK   async lock, source 0
//   TRG_MMCM_LOCK   async lock, source 1
//   QPLL_LOCK       async lock, source 2
//   QPLL_ERROR      async, latched into STICKY[3] only
//   MASK[2:0]       static, bit i excludes source i from counting/restart
//   CLR_CNT         synchronous clear of counters and sticky bits
//   RESTART_REQ     restart request pulse, REQ_LEN cycles wide
//   LOSS_CNT_*      saturating debounced-loss event counters
//   STICKY[3:0]     [2:0] per-source loss latches, [3] QPLL_ERROR latch
//   WD_STATE[2:0]   FSM state code
module lock_watchdog #(
  parameter logic [7:0]  DEBOUNCE    = 8'd16,
  parameter logic [19:0] RESTART_DLY = 20'd40000,
  parameter logic [15:0] ARM_DLY     = 16'd1000,
  parameter logic [3:0]  REQ_LEN     = 4'd8,
  parameter logic [19:0] HOLDOFF     = 20'd100000
) (
  input  logic       STUP_CLK,
  input  logic       SYS_RST,
  input  logic       RUN,
  input  logic       DAQ_MMCM_LOCK,
  input  logic       TRG_MMCM_LOCK,
  input  logic       QPLL_LOCK,
  input  logic       QPLL_ERROR,
  input  logic [2:0] MASK,
  input  logic       CLR_CNT,
  output logic       RESTART_REQ,
  output logic [7:0] LOSS_CNT_DAQ,
  output logic [7:0] LOSS_CNT_TRG,
  output logic [7:0] LOSS_CNT_QPLL,
  output logic [3:0] STICKY,
  output logic [2:0] WD_STATE
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMING = 3'd1,
    ST_ARMED  = 3'd2,
    ST_REQ    = 3'd3,
    ST_HOLD   = 3'd4
  } wd_state_t;

  // Terminal timer values. A zero parameter is treated like one so the
  // subtraction cannot wrap around.
  localparam logic [19:0] ARM_LAST  = (ARM_DLY == 16'd0) ? 20'd0 : {4'd0, ARM_DLY} - 20'd1;
  localparam logic [19:0] RST_LAST  = (RESTART_DLY == 20'd0) ? 20'd0 : RESTART_DLY - 20'd1;
  localparam logic [19:0] REQ_LAST  = (REQ_LEN == 4'd0) ? 20'd0 : {16'd0, REQ_LEN} - 20'd1;
  localparam logic [19:0] HOLD_LAST = (HOLDOFF == 20'd0) ? 20'd0 : HOLDOFF - 20'd1;

  // Synchronizer bit map: 0 RUN, 1 DAQ lock, 2 TRG lock, 3 QPLL lock, 4 QPLL_ERROR
  logic [4:0] async_in;
  logic [4:0] sync1_q, sync1_d;
  logic [4:0] sync2_q, sync2_d;

  logic       run_s;
  logic [2:0] lock_s;
  logic       err_s;

  logic [2:0][7:0] deb_cnt_q, deb_cnt_d;
  logic [2:0]      loss;
  logic [2:0]      loss_prev_q, loss_prev_d;
  logic [2:0]      loss_rise;
  logic            any_loss;

  logic [2:0][7:0] loss_cnt_q, loss_cnt_d;
  logic [3:0]      sticky_q, sticky_d;

  wd_state_t       state_q, state_d;
  logic [19:0]     tmr_q, tmr_d;
  logic            req_q, req_d;

  assign async_in = {QPLL_ERROR, QPLL_LOCK, TRG_MMCM_LOCK, DAQ_MMCM_LOCK, RUN};
  assign run_s    = sync2_q[0];
  assign lock_s   = sync2_q[3:1];
  assign err_s    = sync2_q[4];

  // Debounce. The counter saturates at DEBOUNCE and clears on a high
  // sample. loss is also gated by the current synced sample: that way a
  // drop of exactly DEBOUNCE cycles, which reaches the count on the same
  // edge its first high sample arrives, is not counted. A longer drop
  // still raises loss DEBOUNCE+2 cycles after the input falls.
  always_comb begin
    sync1_d     = async_in;
    sync2_d     = sync1_q;
    deb_cnt_d   = deb_cnt_q;
    loss        = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (lock_s[i]) begin
        deb_cnt_d[i] = 8'd0;
      end else if (deb_cnt_q[i] < DEBOUNCE) begin
        deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
      end
      loss[i] = (deb_cnt_q[i] == DEBOUNCE) && !lock_s[i] && !MASK[i];
    end
    loss_prev_d = loss;
    loss_rise   = loss & ~loss_prev_q;
    any_loss    = |loss;
  end

  // Event counters and sticky latches. Loss edges count only while ARMED,
  // the error latch is live in every state, and a clear overrides both.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    sticky_d   = sticky_q;
    for (int i = 0; i < 3; i++) begin
      if (state_q == ST_ARMED && loss_rise[i]) begin
        sticky_d[i] = 1'b1;
        if (loss_cnt_q[i] != 8'hFF) begin
          loss_cnt_d[i] = loss_cnt_q[i] + 8'd1;
        end
      end
    end
    if (err_s) begin
      sticky_d[3] = 1'b1;
    end
    if (CLR_CNT) begin
      loss_cnt_d = '0;
      sticky_d   = 4'b0000;
    end
  end

  // One timer is shared by all states because only one phase is timed
  // at a time.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    req_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_d = 20'd0;
        if (run_s) begin
          state_d = ST_ARMING;
          // The IDLE cycle that saw RUN counts as the first arm cycle,
          // so ARMED lands ARM_DLY+2 cycles after RUN rises.
          tmr_d   = 20'd1;
        end
      end
      ST_ARMING: begin
        if (!run_s) begin
          state_d = ST_IDLE;
          tmr_d   = 20'd0;
        end else if (tmr_q >= ARM_LAST) begin
          state_d = ST_ARMED;
          tmr_d   = 20'd0;
        end else begin
          tmr_d = tmr_q + 20'd1;
        end
      end
      ST_ARMED: begin
        if (!run_s) begin
          state_d = ST_IDLE;
          tmr_d   = 20'd0;
        end else if (any_loss) begin
          if (tmr_q >= RST_LAST) begin
            state_d = ST_REQ;
            tmr_d   = 20'd0;
            req_d   = 1'b1;
          end else begin
            tmr_d = tmr_q + 20'd1;
          end
        end else begin
          tmr_d = 20'd0;
        end
      end
      ST_REQ: begin
        if (tmr_q >= REQ_LAST) begin
          state_d = ST_HOLD;
          tmr_d   = 20'd0;
        end else begin
          tmr_d = tmr_q + 20'd1;
          req_d = 1'b1;
        end
      end
      ST_HOLD: begin
        // Normally SYS_RST ends this state; the timeout only guards
        // against a reset manager that never responds.
        if (tmr_q >= HOLD_LAST) begin
          state_d = ST_IDLE;
          tmr_d   = 20'd0;
        end else begin
          tmr_d = tmr_q + 20'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = 20'd0;
      end
    endcase
  end

  always_ff @(posedge STUP_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      sync1_q     <= 5'd0;
      sync2_q     <= 5'd0;
      deb_cnt_q   <= '0;
      loss_prev_q <= 3'b000;
      loss_cnt_q  <= '0;
      sticky_q    <= 4'b0000;
      state_q     <= ST_IDLE;
      tmr_q       <= 20'd0;
      req_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_cnt_q   <= deb_cnt_d;
      loss_prev_q <= loss_prev_d;
      loss_cnt_q  <= loss_cnt_d;
      sticky_q    <= sticky_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      req_q       <= req_d;
    end
  end

  assign RESTART_REQ   = req_q;
  assign LOSS_CNT_DAQ  = loss_cnt_q[0];
  assign LOSS_CNT_TRG  = loss_cnt_q[1];
  assign LOSS_CNT_QPLL = loss_cnt_q[2];
  assign STICKY        = sticky_q;
  assign WD_STATE      = state_q;

endmodule

// File: tb/tb_lock_watchdog.sv
// tb_lock_watchdog
// Directed bench for lock_watchdog. It uses short timers so the restart and
// holdoff paths finish quickly. Each check prints one line.
module tb_lock_watchdog;

  localparam int DEB  = 16;
  localparam int RDLY = 100;
  localparam int ARM  = 20;
  localparam int RLEN = 8;
  localparam int HOLD = 50;

  logic       stup_clk   = 1'b0;
  logic       sys_rst    = 1'b1;
  logic       run        = 1'b0;
  logic       daq_lock   = 1'b1;
  logic       trg_lock   = 1'b1;
  logic       qpll_lock  = 1'b1;
  logic       qpll_error = 1'b0;
  logic [2:0] mask       = 3'b000;
  logic       clr_cnt    = 1'b0;

  logic       restart_req;
  logic [7:0] loss_cnt_daq;
  logic [7:0] loss_cnt_trg;
  logic [7:0] loss_cnt_qpll;
  logic [3:0] sticky;
  logic [2:0] wd_state;

  int checks   = 0;
  int failures = 0;
  int req_cycles = 0;

  lock_watchdog #(
    .DEBOUNCE   (8'(DEB)),
    .RESTART_DLY(20'(RDLY)),
    .ARM_DLY    (16'(ARM)),
    .REQ_LEN    (4'(RLEN)),
    .HOLDOFF    (20'(HOLD))
  ) dut (
    .STUP_CLK     (stup_clk),
    .SYS_RST      (sys_rst),
    .RUN          (run),
    .DAQ_MMCM_LOCK(daq_lock),
    .TRG_MMCM_LOCK(trg_lock),
    .QPLL_LOCK    (qpll_lock),
    .QPLL_ERROR   (qpll_error),
    .MASK         (mask),
    .CLR_CNT      (clr_cnt),
    .RESTART_REQ  (restart_req),
    .LOSS_CNT_DAQ (loss_cnt_daq),
    .LOSS_CNT_TRG (loss_cnt_trg),
    .LOSS_CNT_QPLL(loss_cnt_qpll),
    .STICKY       (sticky),
    .WD_STATE     (wd_state)
  );

  always #5 stup_clk = ~stup_clk;

  // Total number of cycles with the request high, sampled at each edge.
  always @(posedge stup_clk) begin
    if (restart_req) req_cycles <= req_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("chk  %s got=%0h ok", tag, got);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge stup_clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (wd_state == st) begin
        found = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    int   base_req;

    // ---- reset, then arming with RUN held high ----
    run = 1'b1;
    repeat (3) @(posedge stup_clk);
    @(negedge stup_clk);
    sys_rst = 1'b0;
    check_eq("rst_state", 32'(wd_state), 32'd0);
    check_eq("rst_req", 32'(restart_req), 32'd0);
    check_eq("rst_cnt", {8'd0, loss_cnt_daq, loss_cnt_trg, loss_cnt_qpll}, 32'd0);
    check_eq("rst_sticky", 32'(sticky), 32'd0);
    repeat (ARM + 1) step();
    check_eq("arming_before", 32'(wd_state), 32'd1);
    step();
    check_eq("armed_at_arm_plus2", 32'(wd_state), 32'd2);
    check_eq("armed_cnt", {8'd0, loss_cnt_daq, loss_cnt_trg, loss_cnt_qpll}, 32'd0);

    // ---- TRG glitches ----
    step();
    trg_lock = 1'b0;
    repeat (10) step();
    trg_lock = 1'b1;
    repeat (30) step();
    check_eq("trg_glitch10", 32'(loss_cnt_trg), 32'd0);
    trg_lock = 1'b0;
    repeat (DEB) step();
    trg_lock = 1'b1;
    repeat (30) step();
    check_eq("trg_glitch_deb", 32'(loss_cnt_trg), 32'd0);
    trg_lock = 1'b0;
    repeat (DEB + 2) step();
    check_eq("trg_cnt_before", 32'(loss_cnt_trg), 32'd0);
    step();
    check_eq("trg_cnt_after", 32'(loss_cnt_trg), 32'd1);
    step();
    trg_lock = 1'b1;
    repeat (30) step();
    check_eq("trg_sticky", 32'(sticky), 32'b0010);
    check_eq("trg_no_req", 32'(req_cycles), 32'd0);
    check_eq("trg_still_armed", 32'(wd_state), 32'd2);

    // ---- QPLL continuous loss -> restart, hold, timeout to IDLE ----
    step();
    qpll_lock = 1'b0;
    repeat (DEB + 2 + RDLY - 1) step();
    check_eq("qpll_req_before", 32'(restart_req), 32'd0);
    for (int i = 0; i < RLEN; i++) begin
      step();
      check_eq($sformatf("qpll_req_hi%0d", i), 32'(restart_req), 32'd1);
    end
    step();
    check_eq("qpll_req_end", 32'(restart_req), 32'd0);
    check_eq("qpll_hold", 32'(wd_state), 32'd4);
    check_eq("qpll_req_len", 32'(req_cycles), 32'(RLEN));
    check_eq("qpll_cnt", 32'(loss_cnt_qpll), 32'd1);
    check_eq("qpll_sticky", 32'(sticky), 32'b0110);
    qpll_lock = 1'b1;
    repeat (HOLD - 1) step();
    check_eq("hold_last", 32'(wd_state), 32'd4);
    step();
    check_eq("hold_to_idle", 32'(wd_state), 32'd0);
    wait_state(3'd2, ARM + 10, "rearm_timeout");

    // ---- masked DAQ loss, then unmask ----
    mask = 3'b001;
    step();
    daq_lock = 1'b0;
    base_req = req_cycles;
    repeat (DEB + RDLY + 30) step();
    check_eq("mask_cnt", 32'(loss_cnt_daq), 32'd0);
    check_eq("mask_no_req", 32'(req_cycles), 32'(base_req));
    check_eq("mask_armed", 32'(wd_state), 32'd2);
    mask = 3'b000;
    found = 1'b0;
    for (int i = 0; i < DEB + RDLY + 2; i++) begin
      step();
      if (restart_req) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("unmask_req_timeout", 32'(found), 32'd1);
    check_eq("unmask_cnt", 32'(loss_cnt_daq), 32'd1);

    // ---- asynchronous reset in the middle of the request ----
    step();
    step();
    check_eq("midreq_state", 32'(wd_state), 32'd3);
    sys_rst = 1'b1;
    #1;
    check_eq("async_rst_req", 32'(restart_req), 32'd0);
    check_eq("async_rst_state", 32'(wd_state), 32'd0);
    check_eq("async_rst_cnt", 32'(loss_cnt_daq), 32'd0);
    daq_lock = 1'b1;
    run      = 1'b0;

    // ---- QPLL_ERROR pulse while IDLE, then clear ----
    @(negedge stup_clk);
    sys_rst = 1'b0;
    step();
    qpll_error = 1'b1;
    step();
    qpll_error = 1'b0;
    repeat (3) step();
    check_eq("err_sticky", 32'(sticky), 32'b1000);
    check_eq("err_idle", 32'(wd_state), 32'd0);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check_eq("clr_sticky", 32'(sticky), 32'd0);

    // ---- 300 debounced DAQ losses, saturation, clear on the 301st ----
    run = 1'b1;
    wait_state(3'd2, ARM + 10, "arm2_timeout");
    for (int i = 0; i < 300; i++) begin
      daq_lock = 1'b0;
      repeat (DEB + 2) step();
      daq_lock = 1'b1;
      repeat (3) step();
      if (i == 0 || i == 253 || i == 254 || i == 299) begin
        check_eq($sformatf("sat_cnt%0d", i + 1), 32'(loss_cnt_daq), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      end
    end
    daq_lock = 1'b0;
    repeat (DEB + 2) step();
    clr_cnt  = 1'b1;
    daq_lock = 1'b1;
    step();
    clr_cnt = 1'b0;
    check_eq("clr_wins_cnt", 32'(loss_cnt_daq), 32'd0);
    check_eq("clr_wins_sticky", 32'(sticky), 32'd0);

    // ---- RUN dropping while ARMED ----
    repeat (5) step();
    run = 1'b0;
    repeat (2) step();
    check_eq("run_drop_armed", 32'(wd_state), 32'd2);
    step();
    check_eq("run_drop_idle", 32'(wd_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
